// File: rtl/tv80_seq_pkg.sv
// Shared types and constants for the TV80 register-file sequencer.
// The state encoding, host op codes and register-pair names are used by the RTL and by the bench.
package tv80_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        RD   = 3'd2,
        SEND = 3'd3,
        LD   = 3'd4,
        DONE = 3'd5
    } seqState_t;

    localparam logic OP_DUMP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    // Register-pair indices as seen on the register-file address ports.
    localparam logic [2:0] B_C = 3'd0;
    localparam logic [2:0] D_E = 3'd1;
    localparam logic [2:0] H_L = 3'd2;
    localparam logic [2:0] IX  = 3'd3;
    localparam logic [2:0] IY  = 3'd7;

    function automatic logic isHolding(input seqState_t s);
        return (s == HOLD) || (s == RD) || (s == SEND) || (s == LD);
    endfunction

endpackage

// File: rtl/tv80_reg_mask_next.sv
// Combinational next-set-bit finder over an 8-bit register-pair mask, searching upward without wrap.
// last=1 means no qualifying bit exists, so curIdx is the final pair (or the mask is empty).
module tv80_reg_mask_next
    import tv80_seq_pkg::*;
(
    input  logic [7:0] mask,
    input  logic [2:0] curIdx,
    input  logic       inclusive,
    output logic [2:0] nextIdx,
    output logic       last
);

    // Scan from the top down so the lowest qualifying bit is the one that sticks.
    always_comb begin
        nextIdx = curIdx;
        last    = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && ((i > int'(curIdx)) || (inclusive && (i == int'(curIdx))))) begin
                nextIdx = 3'(i);
                last    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tv80_reg_seq.sv
// Sequencer/arbiter in front of the TV80 register file: passes CPU controls through, and on a host
// request freezes the CPU at an instruction boundary and streams selected register pairs out or in.
module tv80_reg_seq
    import tv80_seq_pkg::*;
#(
    parameter logic [7:0] REG_MASK     = 8'hFF,
    parameter int          HOLD_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [2:0]  cpu_addra,
    input  logic [2:0]  cpu_addrb,
    input  logic [2:0]  cpu_addrc,
    input  logic [7:0]  cpu_dih,
    input  logic [7:0]  cpu_dil,
    input  logic        cpu_weh,
    input  logic        cpu_wel,
    input  logic        cpu_cen,
    input  logic        cpu_idle,
    output logic        cpu_hold,

    output logic [2:0]  rf_addra,
    output logic [2:0]  rf_addrb,
    output logic [2:0]  rf_addrc,
    output logic [7:0]  rf_dih,
    output logic [7:0]  rf_dil,
    output logic        rf_weh,
    output logic        rf_wel,
    output logic        rf_cen,
    input  logic [7:0]  rf_dobh,
    input  logic [7:0]  rf_dobl,

    input  logic        host_req,
    input  logic        host_op,
    input  logic        host_abort,
    output logic        host_busy,
    output logic        host_done,
    output logic        host_err,

    output logic [15:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,

    input  logic [15:0] ld_data,
    input  logic        ld_valid,
    output logic        ld_ready
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(HOLD_TIMEOUT);
    localparam bit          TIMEOUT_EN  = (HOLD_TIMEOUT != 0);

    seqState_t   state, nextState;
    logic [2:0]  index, nextIndex;
    logic        opLoad, nextOpLoad;
    logic [15:0] holdCnt, nextHoldCnt;
    logic [15:0] stDataReg, nextStData;
    logic        hostErrReg, nextHostErr;

    logic [2:0]  firstIdx;
    logic [2:0]  advIdx;
    logic        maskEmpty;
    logic        advLast;
    logic        stHandshake;
    logic        ldHandshake;

    tv80_reg_mask_next firstFind (
        .mask      (REG_MASK),
        .curIdx    (3'd0),
        .inclusive (1'b1),
        .nextIdx   (firstIdx),
        .last      (maskEmpty)
    );

    tv80_reg_mask_next advFind (
        .mask      (REG_MASK),
        .curIdx    (index),
        .inclusive (1'b0),
        .nextIdx   (advIdx),
        .last      (advLast)
    );

    // Abort outranks a handshake in the same cycle, so it also masks both handshakes here.
    assign stHandshake = (state == SEND) && st_ready && !host_abort;
    assign ldHandshake = (state == LD) && ld_valid && !host_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            index      <= '0;
            opLoad     <= OP_DUMP;
            holdCnt    <= '0;
            stDataReg  <= '0;
            hostErrReg <= 1'b0;
        end else begin
            state      <= nextState;
            index      <= nextIndex;
            opLoad     <= nextOpLoad;
            holdCnt    <= nextHoldCnt;
            stDataReg  <= nextStData;
            hostErrReg <= nextHostErr;
        end
    end

    always_comb begin
        nextState   = state;
        nextIndex   = index;
        nextOpLoad  = opLoad;
        nextHoldCnt = holdCnt;
        nextStData  = stDataReg;
        nextHostErr = 1'b0;

        if ((state != IDLE) && host_abort) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    nextHoldCnt = '0;
                    if (host_req) begin
                        nextOpLoad = host_op;
                        nextState  = HOLD;
                    end
                end
                HOLD: begin
                    if (cpu_idle) begin
                        nextHoldCnt = '0;
                        if (maskEmpty) begin
                            nextState = DONE;
                        end else begin
                            nextIndex = firstIdx;
                            nextState = (opLoad == OP_LOAD) ? LD : RD;
                        end
                    end else if (TIMEOUT_EN && ((holdCnt + 16'd1) == TIMEOUT_CNT)) begin
                        nextHostErr = 1'b1;
                        nextState   = IDLE;
                    end else begin
                        nextHoldCnt = holdCnt + 16'd1;
                    end
                end
                RD: begin
                    nextStData = {rf_dobh, rf_dobl};
                    nextState  = SEND;
                end
                SEND: begin
                    if (stHandshake) begin
                        if (advLast) begin
                            nextState = DONE;
                        end else begin
                            nextIndex = advIdx;
                            nextState = RD;
                        end
                    end
                end
                LD: begin
                    if (ldHandshake) begin
                        if (advLast) begin
                            nextState = DONE;
                        end else begin
                            nextIndex = advIdx;
                        end
                    end
                end
                DONE: begin
                    nextState = IDLE;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    // Outside RD/SEND/LD the core owns the register file untouched; port C is never borrowed.
    always_comb begin
        rf_addra  = cpu_addra;
        rf_addrb  = cpu_addrb;
        rf_addrc  = cpu_addrc;
        rf_dih    = cpu_dih;
        rf_dil    = cpu_dil;
        rf_weh    = cpu_weh;
        rf_wel    = cpu_wel;
        rf_cen    = cpu_cen;

        cpu_hold  = isHolding(state);
        host_busy = isHolding(state);
        host_done = (state == DONE);
        host_err  = hostErrReg;
        st_data   = stDataReg;
        st_valid  = (state == SEND) && !host_abort;
        ld_ready  = (state == LD) && !host_abort;

        case (state)
            RD, SEND: begin
                rf_addrb = index;
                rf_weh   = 1'b0;
                rf_wel   = 1'b0;
            end
            LD: begin
                rf_addra = index;
                rf_addrb = index;
                rf_dih   = ld_data[15:8];
                rf_dil   = ld_data[7:0];
                rf_weh   = ldHandshake;
                rf_wel   = ldHandshake;
                rf_cen   = ldHandshake;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tv80_reg_seq.sv
// Directed bench for tv80_reg_seq: two instances (full mask with a hold timeout, sparse mask without)
// each backed by a behavioural 8x16 register file with asynchronous port-B reads.
module tb_tv80_reg_seq;
    import tv80_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cpuAddra, cpuAddrb, cpuAddrc;
    logic [7:0]  cpuDih, cpuDil;
    logic        cpuWeh, cpuWel, cpuCen, cpuIdle;
    logic        hostOp, stReady, ldValid;
    logic [15:0] ldData;

    logic        hostReq[2], hostAbort[2];
    logic        cpuHold[2], hostBusy[2], hostDone[2], hostErr[2], stValid[2], ldReady[2];
    logic [2:0]  rfAddra[2], rfAddrb[2], rfAddrc[2];
    logic [7:0]  rfDih[2], rfDil[2], rfDobh[2], rfDobl[2];
    logic        rfWeh[2], rfWel[2], rfCen[2];
    logic [15:0] stData[2];

    logic [7:0]  regsH[2][8];
    logic [7:0]  regsL[2][8];
    int          writeCount[2] = '{0, 0};
    logic        initReq[2];
    logic        initFill;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Behavioural register file per instance; initReq loads either a ramp or an all-EE fill.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (initReq[u]) begin
                for (int i = 0; i < 8; i++) begin
                    regsH[u][i] <= initFill ? 8'hEE : 8'(8'h11 * i);
                    regsL[u][i] <= initFill ? 8'hEE : 8'(i);
                end
            end else if (rfCen[u]) begin
                if (rfWeh[u]) regsH[u][rfAddra[u]] <= rfDih[u];
                if (rfWel[u]) regsL[u][rfAddra[u]] <= rfDil[u];
                if (rfWeh[u] || rfWel[u]) writeCount[u] <= writeCount[u] + 1;
            end
        end
    end

    assign rfDobh[0] = regsH[0][rfAddrb[0]];
    assign rfDobl[0] = regsL[0][rfAddrb[0]];
    assign rfDobh[1] = regsH[1][rfAddrb[1]];
    assign rfDobl[1] = regsL[1][rfAddrb[1]];

    tv80_reg_seq #(.REG_MASK(8'hFF), .HOLD_TIMEOUT(4)) dutFull (
        .clk(clk), .reset(reset),
        .cpu_addra(cpuAddra), .cpu_addrb(cpuAddrb), .cpu_addrc(cpuAddrc),
        .cpu_dih(cpuDih), .cpu_dil(cpuDil), .cpu_weh(cpuWeh), .cpu_wel(cpuWel), .cpu_cen(cpuCen),
        .cpu_idle(cpuIdle), .cpu_hold(cpuHold[0]),
        .rf_addra(rfAddra[0]), .rf_addrb(rfAddrb[0]), .rf_addrc(rfAddrc[0]),
        .rf_dih(rfDih[0]), .rf_dil(rfDil[0]), .rf_weh(rfWeh[0]), .rf_wel(rfWel[0]), .rf_cen(rfCen[0]),
        .rf_dobh(rfDobh[0]), .rf_dobl(rfDobl[0]),
        .host_req(hostReq[0]), .host_op(hostOp), .host_abort(hostAbort[0]),
        .host_busy(hostBusy[0]), .host_done(hostDone[0]), .host_err(hostErr[0]),
        .st_data(stData[0]), .st_valid(stValid[0]), .st_ready(stReady),
        .ld_data(ldData), .ld_valid(ldValid), .ld_ready(ldReady[0])
    );

    tv80_reg_seq #(.REG_MASK(8'h88), .HOLD_TIMEOUT(0)) dutSparse (
        .clk(clk), .reset(reset),
        .cpu_addra(cpuAddra), .cpu_addrb(cpuAddrb), .cpu_addrc(cpuAddrc),
        .cpu_dih(cpuDih), .cpu_dil(cpuDil), .cpu_weh(cpuWeh), .cpu_wel(cpuWel), .cpu_cen(cpuCen),
        .cpu_idle(cpuIdle), .cpu_hold(cpuHold[1]),
        .rf_addra(rfAddra[1]), .rf_addrb(rfAddrb[1]), .rf_addrc(rfAddrc[1]),
        .rf_dih(rfDih[1]), .rf_dil(rfDil[1]), .rf_weh(rfWeh[1]), .rf_wel(rfWel[1]), .rf_cen(rfCen[1]),
        .rf_dobh(rfDobh[1]), .rf_dobl(rfDobl[1]),
        .host_req(hostReq[1]), .host_op(hostOp), .host_abort(hostAbort[1]),
        .host_busy(hostBusy[1]), .host_done(hostDone[1]), .host_err(hostErr[1]),
        .st_data(stData[1]), .st_valid(stValid[1]), .st_ready(stReady),
        .ld_data(ldData), .ld_valid(ldValid), .ld_ready(ldReady[1])
    );

    task automatic initRegs(input int u, input logic fill);
        @(negedge clk);
        initFill   = fill;
        initReq[u] = 1'b1;
        @(negedge clk);
        initReq[u] = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        vectors++; if (cpuHold[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cpu_hold: got %b want 0", cpuHold[0]); end
        vectors++; if (hostBusy[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_host_busy: got %b want 0", hostBusy[0]); end
        vectors++; if (hostDone[0] !== 1'b0 || hostErr[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done_err: got %b%b want 00", hostDone[0], hostErr[0]); end
        vectors++; if (stValid[0] !== 1'b0 || ldReady[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_handshake: got %b%b want 00", stValid[0], ldReady[0]); end
        vectors++; if (stData[0] !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_st_data: got %h want 0000", stData[0]); end
        vectors++; if ({rfAddra[0], rfAddrb[0], rfAddrc[0]} !== {3'd5, 3'd2, 3'd6}) begin miscompares++; $display("[TB] FAIL reset_passthru_addr: got %h want %h", {rfAddra[0], rfAddrb[0], rfAddrc[0]}, {3'd5, 3'd2, 3'd6}); end
        vectors++; if ({rfDih[0], rfDil[0], rfWeh[0], rfWel[0], rfCen[0]} !== {8'h12, 8'h34, 3'b101}) begin miscompares++; $display("[TB] FAIL reset_passthru_data: got %h want %h", {rfDih[0], rfDil[0], rfWeh[0], rfWel[0], rfCen[0]}, {8'h12, 8'h34, 3'b101}); end
        @(negedge clk);
        reset  = 1'b0;
        cpuWeh = 1'b0;
        cpuWel = 1'b0;
    endtask

    task automatic test_dump;
        logic [15:0] got[$];
        int lastHs = -1, doneAt = -1, doneCount = 0, w0;
        logic injected = 1'b0, injectPending = 1'b0;
        logic [15:0] expWord, obs;
        initRegs(0, 1'b0);
        cpuIdle = 1'b0; stReady = 1'b1; cpuCen = 1'b1;
        w0 = writeCount[0];
        @(negedge clk);
        hostOp = OP_DUMP; hostReq[0] = 1'b1;
        #1;
        vectors++; if (cpuHold[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL dump_hold_early: got %b want 0", cpuHold[0]); end
        @(negedge clk);
        hostReq[0] = 1'b0;
        #1;
        vectors++; if (cpuHold[0] !== 1'b1 || hostBusy[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL dump_hold_next_cycle: got %b%b want 11", cpuHold[0], hostBusy[0]); end
        @(negedge clk);
        @(negedge clk);
        cpuIdle = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            #1;
            if (injectPending) begin
                vectors++; if (rfWeh[0] !== 1'b0 || rfWel[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL dump_suppress_rd: got %b%b want 00", rfWeh[0], rfWel[0]); end
                cpuWeh = 1'b0; cpuWel = 1'b0; injectPending = 1'b0;
            end
            if (stValid[0] && stReady) begin
                got.push_back(stData[0]);
                lastHs = cyc;
                if (!injected) begin
                    cpuWeh = 1'b1; cpuWel = 1'b1; cpuAddra = 3'd6;
                    #1;
                    vectors++; if (rfWeh[0] !== 1'b0 || rfWel[0] !== 1'b0 || rfAddra[0] !== 3'd6) begin miscompares++; $display("[TB] FAIL dump_suppress_send: got %b%b/%0d want 00/6", rfWeh[0], rfWel[0], rfAddra[0]); end
                    injected = 1'b1; injectPending = 1'b1;
                end
            end
            if (hostDone[0]) begin
                doneCount++;
                doneAt = cyc;
            end
            if (doneCount > 0 && cyc > doneAt + 2) break;
        end
        vectors++; if (got.size() != 8) begin miscompares++; $display("[TB] FAIL dump_word_count: got %0d want 8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            expWord = 16'(16'h1100 * i + i);
            obs = (i < got.size()) ? got[i] : 16'hxxxx;
            vectors++; if (obs !== expWord) begin miscompares++; $display("[TB] FAIL dump_word%0d: got %h want %h", i, obs, expWord); end
        end
        vectors++; if (doneCount != 1 || doneAt != lastHs + 1) begin miscompares++; $display("[TB] FAIL dump_done_timing: got count %0d at %0d want 1 at %0d", doneCount, doneAt, lastHs + 1); end
        vectors++; if (writeCount[0] != w0) begin miscompares++; $display("[TB] FAIL dump_no_write: got %0d writes want 0", writeCount[0] - w0); end
        vectors++; if (cpuHold[0] !== 1'b0 || hostBusy[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL dump_release: got %b%b want 00", cpuHold[0], hostBusy[0]); end
    endtask

    task automatic test_ready_toggle;
        logic [15:0] got[$];
        logic [15:0] prevData = '0, expWord, obs;
        logic prevStall = 1'b0;
        int stallChecks = 0;
        initRegs(0, 1'b0);
        cpuIdle = 1'b1;
        @(negedge clk);
        hostOp = OP_DUMP; hostReq[0] = 1'b1;
        @(negedge clk);
        hostReq[0] = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            stReady = (cyc % 3 == 0);
            #1;
            if (stValid[0] && prevStall) begin
                stallChecks++;
                vectors++; if (stData[0] !== prevData) begin miscompares++; $display("[TB] FAIL toggle_stable: got %h want %h", stData[0], prevData); end
            end
            prevStall = stValid[0] && !stReady;
            prevData  = stData[0];
            if (stValid[0] && stReady) got.push_back(stData[0]);
            if (hostDone[0]) break;
        end
        stReady = 1'b1;
        vectors++; if (stallChecks == 0) begin miscompares++; $display("[TB] FAIL toggle_stalls_seen: got %0d want >0", stallChecks); end
        vectors++; if (got.size() != 8) begin miscompares++; $display("[TB] FAIL toggle_word_count: got %0d want 8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            expWord = 16'(16'h1100 * i + i);
            obs = (i < got.size()) ? got[i] : 16'hxxxx;
            vectors++; if (obs !== expWord) begin miscompares++; $display("[TB] FAIL toggle_word%0d: got %h want %h", i, obs, expWord); end
        end
    endtask

    task automatic test_load;
        logic [15:0] words[2] = '{16'hA5A5, 16'h5A5A};
        int w = 0, readyCycles = 0, doneCount = 0, w0;
        initRegs(1, 1'b1);
        cpuIdle = 1'b1; ldValid = 1'b0;
        w0 = writeCount[1];
        @(negedge clk);
        hostOp = OP_LOAD; hostReq[1] = 1'b1;
        @(negedge clk);
        hostReq[1] = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            ldData  = (w < 2) ? words[w] : 16'h0000;
            ldValid = (w < 2);
            #1;
            if (ldReady[1]) readyCycles++;
            if (ldReady[1] && ldValid) w++;
            if (hostDone[1]) doneCount++;
        end
        ldValid = 1'b0;
        vectors++; if (w != 2 || readyCycles != 2) begin miscompares++; $display("[TB] FAIL load_handshakes: got %0d words %0d ready cycles want 2/2", w, readyCycles); end
        vectors++; if (doneCount != 1) begin miscompares++; $display("[TB] FAIL load_done_once: got %0d want 1", doneCount); end
        vectors++; if ({regsH[1][IX], regsL[1][IX]} !== 16'hA5A5) begin miscompares++; $display("[TB] FAIL load_pair3: got %h want a5a5", {regsH[1][IX], regsL[1][IX]}); end
        vectors++; if ({regsH[1][IY], regsL[1][IY]} !== 16'h5A5A) begin miscompares++; $display("[TB] FAIL load_pair7: got %h want 5a5a", {regsH[1][IY], regsL[1][IY]}); end
        vectors++; if ({regsH[1][B_C], regsL[1][H_L], regsH[1][4], regsL[1][6]} !== 32'hEEEEEEEE) begin miscompares++; $display("[TB] FAIL load_others_untouched: got %h want eeeeeeee", {regsH[1][B_C], regsL[1][H_L], regsH[1][4], regsL[1][6]}); end
        vectors++; if (writeCount[1] - w0 != 2) begin miscompares++; $display("[TB] FAIL load_write_count: got %0d want 2", writeCount[1] - w0); end
    endtask

    task automatic test_abort;
        logic firstSeen = 1'b0;
        int doneCount = 0;
        initRegs(0, 1'b1);
        cpuIdle = 1'b1;
        @(negedge clk);
        hostOp = OP_LOAD; hostReq[0] = 1'b1;
        @(negedge clk);
        hostReq[0] = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            ldData = 16'h1234; ldValid = 1'b1;
            #1;
            if (ldReady[0]) begin
                firstSeen = 1'b1;
                break;
            end
        end
        vectors++; if (firstSeen !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_first_handshake: got %b want 1", firstSeen); end
        @(negedge clk);
        ldData = 16'h4321; ldValid = 1'b1; hostAbort[0] = 1'b1;
        #1;
        vectors++; if (rfWeh[0] !== 1'b0 || rfWel[0] !== 1'b0 || ldReady[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_blocks_write: got %b%b%b want 000", rfWeh[0], rfWel[0], ldReady[0]); end
        @(negedge clk);
        hostAbort[0] = 1'b0; ldValid = 1'b0;
        #1;
        vectors++; if (cpuHold[0] !== 1'b0 || hostBusy[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_release: got %b%b want 00", cpuHold[0], hostBusy[0]); end
        if (hostDone[0]) doneCount++;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            #1;
            if (hostDone[0]) doneCount++;
        end
        vectors++; if (doneCount != 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", doneCount); end
        vectors++; if ({regsH[0][B_C], regsL[0][B_C]} !== 16'h1234) begin miscompares++; $display("[TB] FAIL abort_pair0: got %h want 1234", {regsH[0][B_C], regsL[0][B_C]}); end
        vectors++; if ({regsH[0][D_E], regsL[0][D_E]} !== 16'hEEEE) begin miscompares++; $display("[TB] FAIL abort_pair1: got %h want eeee", {regsH[0][D_E], regsL[0][D_E]}); end
    endtask

    task automatic test_timeout;
        int holdCycles = 0, errCount = 0, errAt = -1;
        initRegs(0, 1'b1);
        cpuIdle = 1'b0;
        cpuWeh = 1'b1; cpuWel = 1'b1; cpuCen = 1'b1;
        cpuAddra = 3'd5; cpuDih = 8'h3C; cpuDil = 8'hC3;
        @(negedge clk);
        hostOp = OP_DUMP; hostReq[0] = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) hostReq[0] = 1'b0;
            #1;
            if (cpuHold[0]) begin
                holdCycles++;
                vectors++; if (rfWeh[0] !== 1'b1 || rfWel[0] !== 1'b1 || rfAddra[0] !== 3'd5) begin miscompares++; $display("[TB] FAIL timeout_passthru: got %b%b/%0d want 11/5", rfWeh[0], rfWel[0], rfAddra[0]); end
            end
            if (hostErr[0]) begin
                errCount++;
                errAt = cyc;
            end
        end
        cpuWeh = 1'b0; cpuWel = 1'b0;
        vectors++; if (holdCycles != 4) begin miscompares++; $display("[TB] FAIL timeout_hold_cycles: got %0d want 4", holdCycles); end
        vectors++; if (errCount != 1 || errAt != 5) begin miscompares++; $display("[TB] FAIL timeout_err_pulse: got %0d at %0d want 1 at 5", errCount, errAt); end
        vectors++; if (hostBusy[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_idle: got busy %b want 0", hostBusy[0]); end
        vectors++; if ({regsH[0][5], regsL[0][5]} !== 16'h3CC3) begin miscompares++; $display("[TB] FAIL timeout_cpu_write: got %h want 3cc3", {regsH[0][5], regsL[0][5]}); end
    endtask

    task automatic test_reset_in_send;
        logic [15:0] got[$];
        logic [15:0] expWord, obs;
        logic seen = 1'b0;
        int doneCount = 0;
        initRegs(0, 1'b0);
        cpuIdle = 1'b1; stReady = 1'b0;
        @(negedge clk);
        hostOp = OP_DUMP; hostReq[0] = 1'b1;
        @(negedge clk);
        hostReq[0] = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            #1;
            if (stValid[0]) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_send_reached: got %b want 1", seen); end
        reset = 1'b1;
        #1;
        vectors++; if (stValid[0] !== 1'b0 || cpuHold[0] !== 1'b0 || hostBusy[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_immediate: got %b%b%b want 000", stValid[0], cpuHold[0], hostBusy[0]); end
        @(negedge clk);
        reset = 1'b0; stReady = 1'b1;
        @(negedge clk);
        hostOp = OP_DUMP; hostReq[0] = 1'b1;
        @(negedge clk);
        hostReq[0] = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            #1;
            if (stValid[0] && stReady) got.push_back(stData[0]);
            if (hostDone[0]) begin
                doneCount++;
                break;
            end
        end
        vectors++; if (got.size() != 8 || doneCount != 1) begin miscompares++; $display("[TB] FAIL rst_redump_count: got %0d words %0d done want 8/1", got.size(), doneCount); end
        for (int i = 0; i < 8; i++) begin
            expWord = 16'(16'h1100 * i + i);
            obs = (i < got.size()) ? got[i] : 16'hxxxx;
            vectors++; if (obs !== expWord) begin miscompares++; $display("[TB] FAIL rst_redump_word%0d: got %h want %h", i, obs, expWord); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cpuAddra = 3'd5; cpuAddrb = 3'd2; cpuAddrc = 3'd6;
        cpuDih = 8'h12; cpuDil = 8'h34;
        cpuWeh = 1'b1; cpuWel = 1'b0; cpuCen = 1'b1; cpuIdle = 1'b0;
        hostOp = OP_DUMP; stReady = 1'b1; ldValid = 1'b0; ldData = 16'h0000;
        initFill = 1'b0;
        for (int u = 0; u < 2; u++) begin
            hostReq[u] = 1'b0; hostAbort[u] = 1'b0; initReq[u] = 1'b0;
        end
        test_reset();
        test_dump();
        test_ready_toggle();
        test_load();
        test_abort();
        test_timeout();
        test_reset_in_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
